alu_wb_collector: RTL and testbench
===================================

Name: alu_wb_collector

Overview:
- Consumer end of the registered arithmetic-unit result interface.
- Issue side: the core sends an operation to a 1-cycle-latency arith unit (AND/OR/XOR logic unit class) together with a destination register tag.
- Result side: one cycle later this block pairs the unit's result with the delayed tag and buffers the pair in a small FIFO.
- Buffered pairs are presented to the register-file write port under valid/ready backpressure. Issue is throttled so no result is ever lost.

Parameters:
- XLEN, 64, operand/result width (matches core RISCV_ARCH).
- TAG_W, 6, destination tag width (register index incl. FPU bank bit).
- DEPTH, 4, FIFO entries; power of two, >= 2.

Ports:
- i_clk  in  1  clock, rising edge.
- i_nrst  in  1  reset, asynchronous, active-low.
- i_issue_valid  in  1  operation issued to arith unit this cycle.
- i_issue_tag  in  TAG_W  destination register of issued op.
- o_issue_ready  out  1  collector can accept an issue this cycle.
- i_res  in  XLEN  arith unit registered result; valid the cycle after an accepted issue.
- o_wb_valid  out  1  FIFO head holds a result.
- o_wb_tag  out  TAG_W  head destination tag.
- o_wb_data  out  XLEN  head result data.
- i_wb_ready  in  1  register file accepts head this cycle.
- o_count  out  $clog2(DEPTH)+1  entries currently stored.

Behaviour:
- Decided: reset i_nrst, asynchronous, active-low; clock i_clk. All state is cleared on the i_nrst falling edge, with no dependency on the clock.
- Reset state:
  - wr_ptr = 0, rd_ptr = 0, count = 0.
  - pend_valid = 0, pend_tag = 0.
  - Storage contents are don't-care, but o_wb_tag/o_wb_data must read 0 while empty.
  - Resulting outputs: o_issue_ready = 1, o_wb_valid = 0, o_count = 0.
- Issue acceptance: issue_fire = i_issue_valid & o_issue_ready.
  - o_issue_ready = (count + pend_valid) < DEPTH.
  - Purely from registers; no combinational path from any input.
- Pending stage: on issue_fire, set pend_valid <= 1 and pend_tag <= i_issue_tag; otherwise pend_valid <= 0.
- Capture: in a cycle with pend_valid = 1, push {pend_tag, i_res} at wr_ptr and increment wr_ptr (mod DEPTH).
  - Exception: if pend_tag == 0 (x0 destination), discard the result and do not push.
- Pop: wb_fire = o_wb_valid & i_wb_ready. On pop, increment rd_ptr (mod DEPTH).
- Head outputs: o_wb_valid = (count != 0); o_wb_tag and o_wb_data come from the entry at rd_ptr, masked to 0 when empty.
- Count update:
  - count_next = count + push - pop.
  - Push and pop in the same cycle leave count unchanged, including when count == DEPTH-1 or count == 1.
  - Pop from empty cannot happen (gated by o_wb_valid).
  - Push into full cannot happen (guaranteed by the issue throttle). Bench asserts this.
- Latency:
  - issue_fire at cycle N; capture at N+1; o_wb_valid high at N+2 (no bypass).
  - Back-to-back issues sustain 1 result/cycle when i_wb_ready is held 1.
- Order: strict FIFO; results leave in issue order.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally; count disambiguates full from empty.
- o_wb_valid/o_wb_tag/o_wb_data must hold stable while o_wb_valid = 1 and i_wb_ready = 0.
- Reset mid-operation: pending and stored results are dropped. The first cycle after reset release behaves as the reset state; no spurious push even if i_res is non-zero.

Test Plan:
- Single op: issue tag 5 at N, i_res = 0x00FF_00FF_00FF_00FF at N+1, wb_ready = 1 -> o_wb_valid at N+2 only, with tag 5 and that data; o_count returns to 0 at N+3.
- Streaming: 8 consecutive issues, tags 1..8, i_res = tag*0x11, wb_ready = 1 -> 8 consecutive wb beats in order, o_issue_ready never drops, o_count <= 1.
- Backpressure: wb_ready = 0, issue continuously -> exactly 4 issues accepted. o_issue_ready falls once count + pend_valid reaches 4; o_count = 4; outputs stable. Release wb_ready -> 4 in-order beats, then o_issue_ready = 1.
- Simultaneous push/pop at full-1: count = 3, pend_valid = 1, wb_ready = 1 -> count stays 3, correct head advance, pointer wrap at entry 3->0 verified.
- x0 discard: issue tag 0 then tag 7 -> only tag 7 appears on wb; o_count never exceeds 1.
- Async reset: assert i_nrst low mid-clock with count = 2 and pend_valid = 1 -> outputs go to reset values immediately; after release no wb beat appears, o_count = 0, o_issue_ready = 1.

Source files
------------

// File: rtl/alu_wb_collector_if.sv
// alu_wb_collector_if : issue/result/write-back bundle between the core and the result collector.
`default_nettype none

interface alu_wb_collector_if #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 6,
  parameter int DEPTH = 4
);
  logic                     i_issue_valid;
  logic [TAG_W-1:0]         i_issue_tag;
  logic                     o_issue_ready;
  logic [XLEN-1:0]          i_res;
  logic                     o_wb_valid;
  logic [TAG_W-1:0]         o_wb_tag;
  logic [XLEN-1:0]          o_wb_data;
  logic                     i_wb_ready;
  logic [$clog2(DEPTH):0]   o_count;

  // Core / register-file side
  modport master (
    output i_issue_valid, i_issue_tag, i_res, i_wb_ready,
    input  o_issue_ready, o_wb_valid, o_wb_tag, o_wb_data, o_count
  );

  // Collector side
  modport slave (
    input  i_issue_valid, i_issue_tag, i_res, i_wb_ready,
    output o_issue_ready, o_wb_valid, o_wb_tag, o_wb_data, o_count
  );
endinterface

`default_nettype wire

// File: rtl/alu_wb_collector.sv
// alu_wb_collector : pairs 1-cycle arith results with their delayed tag and buffers them for write-back.
`default_nettype none

module alu_wb_collector #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 6,
  parameter int DEPTH = 4
) (
  input  logic               i_clk,
  input  logic               i_nrst,
  alu_wb_collector_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int OW = CW + 1;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             pend_valid_q, pend_valid_d;
  logic [TAG_W-1:0] pend_tag_q, pend_tag_d;
  logic [TAG_W-1:0] mem_tag_q  [DEPTH];
  logic [TAG_W-1:0] mem_tag_d  [DEPTH];
  logic [XLEN-1:0]  mem_data_q [DEPTH];
  logic [XLEN-1:0]  mem_data_d [DEPTH];

  logic [OW-1:0]    occupancy;
  logic             issue_ready;
  logic             issue_fire;
  logic             wb_valid;
  logic             push;
  logic             pop;

  always_comb begin
    // An in-flight result already owns a slot, so it counts against the throttle.
    occupancy    = {1'b0, count_q} + OW'(pend_valid_q);
    issue_ready  = occupancy < OW'(DEPTH);
    issue_fire   = bus.i_issue_valid & issue_ready;
    wb_valid     = (count_q != '0);
    push         = pend_valid_q & (pend_tag_q != '0);
    pop          = wb_valid & bus.i_wb_ready;

    pend_valid_d = issue_fire;
    pend_tag_d   = issue_fire ? bus.i_issue_tag : pend_tag_q;
    wr_ptr_d     = wr_ptr_q + AW'(push);
    rd_ptr_d     = rd_ptr_q + AW'(pop);
    count_d      = count_q + CW'(push) - CW'(pop);

    mem_tag_d    = mem_tag_q;
    mem_data_d   = mem_data_q;
    if (push) begin
      mem_tag_d[wr_ptr_q]  = pend_tag_q;
      mem_data_d[wr_ptr_q] = bus.i_res;
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      pend_valid_q <= 1'b0;
      pend_tag_q   <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      pend_valid_q <= pend_valid_d;
      pend_tag_q   <= pend_tag_d;
    end
  end

  // Storage needs no reset: the head is masked whenever count is zero.
  always_ff @(posedge i_clk) begin
    mem_tag_q  <= mem_tag_d;
    mem_data_q <= mem_data_d;
  end

  assign bus.o_issue_ready = issue_ready;
  assign bus.o_wb_valid    = wb_valid;
  assign bus.o_wb_tag      = wb_valid ? mem_tag_q[rd_ptr_q]  : '0;
  assign bus.o_wb_data     = wb_valid ? mem_data_q[rd_ptr_q] : '0;
  assign bus.o_count       = count_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_wb_collector.sv
// tb_alu_wb_collector : vector table, directed corner sequences and random traffic against a queue model.
`default_nettype none

module tb_alu_wb_collector;

  localparam int XLEN  = 64;
  localparam int TAG_W = 6;
  localparam int DEPTH = 4;

  logic clk;
  logic nrst;
  int   tests;
  int   fails;

  alu_wb_collector_if #(.XLEN(XLEN), .TAG_W(TAG_W), .DEPTH(DEPTH)) bus_if ();

  alu_wb_collector #(.XLEN(XLEN), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .i_clk  (clk),
    .i_nrst (nrst),
    .bus    (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  data;
  } entry_t;

  typedef struct {
    bit               iv;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  res;
    bit               wbr;
    bit               e_ready;
    bit               e_valid;
    logic [TAG_W-1:0] e_tag;
    logic [XLEN-1:0]  e_data;
    int               e_count;
  } vec_t;

  // Reference model: results waiting for write-back, plus the op issued last cycle.
  entry_t           mq[$];
  bit               m_pend_v;
  logic [TAG_W-1:0] m_pend_tag;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_pend_v   = 1'b0;
    m_pend_tag = '0;
  endtask

  task automatic compare_model();
    bit exp_valid;
    exp_valid = (mq.size() != 0);
    check("model_issue_ready", 64'(bus_if.o_issue_ready), 64'((mq.size() + int'(m_pend_v)) < DEPTH));
    check("model_wb_valid",    64'(bus_if.o_wb_valid),    64'(exp_valid));
    check("model_wb_tag",      64'(bus_if.o_wb_tag),      exp_valid ? 64'(mq[0].tag) : 64'd0);
    check("model_wb_data",     bus_if.o_wb_data,          exp_valid ? mq[0].data : 64'd0);
    check("model_count",       64'(bus_if.o_count),       64'(mq.size()));
  endtask

  // One clock: drive inputs, advance model, clock, compare after the edge.
  task automatic cycle(input bit iv, input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] res,
                       input bit wbr, output bit dut_fire);
    bit m_fire;
    bit m_pop;
    bus_if.i_issue_valid = iv;
    bus_if.i_issue_tag   = tag;
    bus_if.i_res         = res;
    bus_if.i_wb_ready    = wbr;
    dut_fire = iv & bus_if.o_issue_ready;
    m_fire = iv && ((mq.size() + int'(m_pend_v)) < DEPTH);
    m_pop  = wbr && (mq.size() != 0);
    if (m_pop) void'(mq.pop_front());
    if (m_pend_v && m_pend_tag != '0) begin
      check("no_push_into_full", 64'(mq.size() < DEPTH), 64'd1);
      mq.push_back('{tag: m_pend_tag, data: res});
    end
    m_pend_v   = m_fire;
    m_pend_tag = tag;
    @(posedge clk);
    #1;
    compare_model();
  endtask

  task automatic do_reset();
    bus_if.i_issue_valid = 1'b0;
    bus_if.i_issue_tag   = '0;
    bus_if.i_res         = '0;
    bus_if.i_wb_ready    = 1'b0;
    nrst = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    nrst = 1'b1;
  endtask

  vec_t vecs[8];

  initial begin
    bit f;
    int accepted;
    tests = 0;
    fails = 0;
    nrst  = 1'b0;
    bus_if.i_issue_valid = 1'b0;
    bus_if.i_issue_tag   = '0;
    bus_if.i_res         = '0;
    bus_if.i_wb_ready    = 1'b0;
    model_clear();

    // Single op (tag 5) followed by x0 discard (tag 0 then tag 7).
    vecs[0] = '{1, 6'd5, 64'h0,                  1, 1, 0, 6'd0, 64'h0,                  0};
    vecs[1] = '{0, 6'd0, 64'h00FF_00FF_00FF_00FF, 1, 1, 1, 6'd5, 64'h00FF_00FF_00FF_00FF, 1};
    vecs[2] = '{0, 6'd0, 64'hDEAD,               1, 1, 0, 6'd0, 64'h0,                  0};
    vecs[3] = '{1, 6'd0, 64'h5555,               1, 1, 0, 6'd0, 64'h0,                  0};
    vecs[4] = '{1, 6'd7, 64'h1234,               1, 1, 0, 6'd0, 64'h0,                  0};
    vecs[5] = '{0, 6'd0, 64'h77,                 0, 1, 1, 6'd7, 64'h77,                 1};
    vecs[6] = '{0, 6'd0, 64'hBAD,                0, 1, 1, 6'd7, 64'h77,                 1};
    vecs[7] = '{0, 6'd0, 64'hBAD,                1, 1, 0, 6'd0, 64'h0,                  0};

    repeat (2) @(posedge clk);
    #1;
    check("reset_issue_ready", 64'(bus_if.o_issue_ready), 64'd1);
    check("reset_wb_valid",    64'(bus_if.o_wb_valid),    64'd0);
    check("reset_wb_tag",      64'(bus_if.o_wb_tag),      64'd0);
    check("reset_wb_data",     bus_if.o_wb_data,          64'd0);
    check("reset_count",       64'(bus_if.o_count),       64'd0);
    nrst = 1'b1;

    for (int i = 0; i < 8; i++) begin
      cycle(vecs[i].iv, vecs[i].tag, vecs[i].res, vecs[i].wbr, f);
      check($sformatf("vec%0d_issue_ready", i), 64'(bus_if.o_issue_ready), 64'(vecs[i].e_ready));
      check($sformatf("vec%0d_wb_valid", i),    64'(bus_if.o_wb_valid),    64'(vecs[i].e_valid));
      check($sformatf("vec%0d_wb_tag", i),      64'(bus_if.o_wb_tag),      64'(vecs[i].e_tag));
      check($sformatf("vec%0d_wb_data", i),     bus_if.o_wb_data,          vecs[i].e_data);
      check($sformatf("vec%0d_count", i),       64'(bus_if.o_count),       64'(vecs[i].e_count));
    end

    // Streaming: tags 1..8 back to back, result arrives one cycle after each issue.
    for (int i = 0; i < 10; i++) begin
      cycle(i < 8, TAG_W'(i + 1), 64'(i * 'h11), 1'b1, f);
      check("stream_issue_ready", 64'(bus_if.o_issue_ready), 64'd1);
      check("stream_count_le1",   64'(bus_if.o_count <= 1), 64'd1);
      check("stream_wb_valid",    64'(bus_if.o_wb_valid), 64'(i >= 1 && i <= 8));
      if (i >= 1 && i <= 8) begin
        check("stream_wb_tag",  64'(bus_if.o_wb_tag), 64'(i));
        check("stream_wb_data", bus_if.o_wb_data,     64'(i * 'h11));
      end
    end

    // Backpressure: only DEPTH issues get in, head stays frozen, then drains in order.
    do_reset();
    accepted = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, TAG_W'(10 + i), 64'h100 + 64'(i), 1'b0, f);
      if (f) accepted++;
      if (i >= 3) begin
        check("bp_hold_tag",  64'(bus_if.o_wb_tag), 64'd10);
        check("bp_hold_data", bus_if.o_wb_data,     64'h101);
      end
    end
    check("bp_accepted",    64'(accepted),             64'd4);
    check("bp_count_full",  64'(bus_if.o_count),       64'd4);
    check("bp_ready_low",   64'(bus_if.o_issue_ready), 64'd0);
    for (int j = 0; j < 4; j++) begin
      check("bp_drain_tag",  64'(bus_if.o_wb_tag), 64'(10 + j));
      check("bp_drain_data", bus_if.o_wb_data,     64'h101 + 64'(j));
      cycle(1'b0, '0, 64'hF00D, 1'b1, f);
    end
    check("bp_ready_after", 64'(bus_if.o_issue_ready), 64'd1);

    // Push and pop together at count 3 with a result in flight; write pointer wraps 3 -> 0.
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, TAG_W'(20 + i), 64'h200 + 64'(i), 1'b0, f);
    check("f1_count3", 64'(bus_if.o_count), 64'd3);
    cycle(1'b1, 6'd24, 64'h204, 1'b1, f);
    check("f1_count_hold", 64'(bus_if.o_count),  64'd3);
    check("f1_head_tag",   64'(bus_if.o_wb_tag), 64'd21);
    check("f1_head_data",  bus_if.o_wb_data,     64'h202);
    cycle(1'b1, 6'd25, 64'h205, 1'b1, f);
    cycle(1'b0, 6'd0,  64'h206, 1'b1, f);
    cycle(1'b0, 6'd0,  64'h207, 1'b1, f);
    check("f1_wrap_tag",  64'(bus_if.o_wb_tag), 64'd25);
    check("f1_wrap_data", bus_if.o_wb_data,     64'h206);
    repeat (3) cycle(1'b0, '0, 64'h0, 1'b1, f);

    // Asynchronous reset mid-cycle with stored and in-flight results.
    do_reset();
    cycle(1'b1, 6'd3, 64'h0,  1'b0, f);
    cycle(1'b1, 6'd4, 64'h33, 1'b0, f);
    cycle(1'b1, 6'd9, 64'h44, 1'b0, f);
    check("ar_count_before", 64'(bus_if.o_count), 64'd2);
    #3;
    nrst = 1'b0;
    #1;
    model_clear();
    check("ar_issue_ready", 64'(bus_if.o_issue_ready), 64'd1);
    check("ar_wb_valid",    64'(bus_if.o_wb_valid),    64'd0);
    check("ar_wb_tag",      64'(bus_if.o_wb_tag),      64'd0);
    check("ar_wb_data",     bus_if.o_wb_data,          64'd0);
    check("ar_count",       64'(bus_if.o_count),       64'd0);
    @(posedge clk);
    #1;
    nrst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 6'd9, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, f);
      check("ar_post_wb_valid", 64'(bus_if.o_wb_valid), 64'd0);
    end

    // Random traffic against the queue model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic [TAG_W-1:0] t;
      t = ($urandom_range(0, 7) == 0) ? '0 : TAG_W'($urandom_range(1, 63));
      cycle($urandom_range(0, 3) != 0, t, {$urandom, $urandom}, $urandom_range(0, 9) < 6, f);
    end
    repeat (DEPTH + 2) cycle(1'b0, '0, {$urandom, $urandom}, 1'b1, f);
    check("rand_drained", 64'(bus_if.o_count), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
